// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader.
//   state_e          : loader FSM states
//   WORD_BYTES       : bytes per instruction word (4)
//   COUNT_W          : width of the word count carried in the header (13)
//   BYTE_CNT_W       : width of the byte-in-word counter
//   count_exceeds()  : true when a header count does not fit the imem
// Optional feature macro used by the loader: IMEM_LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HEADER = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int COUNT_W    = 13;
    localparam int BYTE_CNT_W = 2;

    // A count equal to the imem depth is legal; only strictly larger counts
    // would overrun the memory.
    function automatic logic count_exceeds(input logic [COUNT_W-1:0] n,
                                           input int unsigned addr_w);
        return 32'(n) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Shifts accepted bytes MSB-first into a word and pulses word_valid for one
// cycle after every WORD_BYTES-th byte. word_data holds the completed word
// during that pulse.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low
//   byte_en    : a byte is transferred this cycle
//   byte_data  : the transferred byte
//   word_valid : one-cycle pulse, word_data is a complete word
//   word_data  : assembled word (first byte in the top byte lane)
// ---------------------------------------------------------------------------
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [DATA_W-1:0] word_data
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(WORD_BYTES - 1);

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  valid_q, valid_d;

    // The counter wraps to 0 on the last byte so a new word can start in
    // the same cycle the finished word is being presented.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        if (byte_en) begin
            shift_d = {shift_q[DATA_W-9:0], byte_data};
            if (cnt_q == LAST_BYTE) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word_data  = shift_q;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a byte stream (header word = word count N, then N payload words)
// and writes the payload into instruction memory at word addresses 0..N-1,
// holding the processor in reset until the load completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// word equal to the XOR of all payload words before declaring success.
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous, active-low
//   byte_valid  : source offers byte_data
//   byte_data   : stream byte
//   byte_ready  : loader accepts a byte (transfer when valid && ready)
//   imem_wren   : one-cycle write strobe toward imem
//   imem_addr   : write word address
//   imem_data   : write word
//   cpu_hold    : keep the processor in reset
//   done        : load completed successfully
//   error       : load aborted
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] WORD_ONE = (ADDR_W + 1)'(1);

    state_e               state_q, state_d;
    logic                 active_q, active_d;
    logic [ADDR_W:0]      word_cnt_q, word_cnt_d;
    logic [COUNT_W-1:0]   count_q, count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]    csum_q, csum_d;
`endif

    logic                 byte_fire;
    logic                 word_valid;
    logic [DATA_W-1:0]    word_data;
    logic                 in_rx;
    logic                 write_now;
    logic                 last_word;
    logic [COUNT_W-1:0]   hdr_count;

    word_assembler #(
        .DATA_W (DATA_W)
    ) u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .byte_en    (byte_fire),
        .byte_data  (byte_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // active_q keeps byte_ready low while reset is held and for the cycle
    // it is released, so ready first rises on the first edge after release.
    assign in_rx      = (state_q == HEADER) || (state_q == LOAD) || (state_q == CHECK);
    assign write_now  = word_valid && (state_q == LOAD);
    assign byte_ready = active_q && in_rx && !write_now;
    assign byte_fire  = byte_valid && byte_ready;

    assign hdr_count  = word_data[COUNT_W-1:0];
    assign last_word  = (32'(word_cnt_q) + 32'd1) == 32'(count_q);

    // Word counter is one bit wider than the address so N = 2^ADDR_W is
    // representable; the FSM leaves LOAD on the last write, so the
    // truncated address never wraps back onto 0.
    always_comb begin
        state_d    = state_q;
        active_d   = 1'b1;
        word_cnt_d = word_cnt_q;
        count_d    = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            HEADER: begin
                if (word_valid) begin
                    count_d    = hdr_count;
                    word_cnt_d = '0;
                    if (count_exceeds(hdr_count, ADDR_W)) begin
                        state_d = ERROR;
                    end else if (hdr_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_valid) begin
                    word_cnt_d = word_cnt_q + WORD_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ word_data;
`endif
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (word_valid) begin
                    state_d = (word_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= HEADER;
            active_q   <= 1'b0;
            word_cnt_q <= '0;
            count_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            word_cnt_q <= word_cnt_d;
            count_q    <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign imem_wren = write_now;
    assign imem_addr = word_cnt_q[ADDR_W-1:0];
    assign imem_data = word_data;
    assign cpu_hold  = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. A word-level model turns each stream into
// the list of writes and the final done/error outcome it must produce; a
// negedge monitor checks every imem write against that list.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] stream_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] log_addr_q[$];
    logic [31:0] log_data_q[$];
    logic        exp_done;
    logic        exp_error;
    logic        prev_wren = 1'b0;
    logic        stream_abort = 1'b0;

    always #5 clock = ~clock;

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_wren  (imem_wren),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Every write the DUT makes must be the next one the model predicts.
    always @(negedge clock) begin
        if (reset) begin
            if (imem_wren) begin
                checkOutput("wren_vs_ready", 32'(byte_ready), 32'd0);
                checkOutput("wren_single_cycle", 32'(prev_wren), 32'd0);
                if (exp_addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL extra_write: got addr 0x%0h data 0x%0h, required no write",
                             imem_addr, imem_data);
                end else begin
                    checkOutput("write_addr", 32'(imem_addr), exp_addr_q.pop_front());
                    checkOutput("write_data", imem_data, exp_data_q.pop_front());
                end
                log_addr_q.push_back(32'(imem_addr));
                log_data_q.push_back(imem_data);
            end
            prev_wren = imem_wren;
        end else begin
            prev_wren = 1'b0;
        end
    end

    // Word-level model: header count, payload writes, optional trailer.
    task automatic build_expected();
        int n;
        logic [31:0] x;
        logic [31:0] hdr;
        exp_addr_q.delete();
        exp_data_q.delete();
        hdr       = stream_q[0];
        n         = int'(hdr[12:0]);
        exp_done  = 1'b0;
        exp_error = 1'b0;
        x         = 32'd0;
        if (n > (1 << ADDR_W)) begin
            exp_error = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(32'(i));
                exp_data_q.push_back(stream_q[i+1]);
                x = x ^ stream_q[i+1];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_done  = (stream_q[n+1] == x);
            exp_error = !exp_done;
`else
            exp_done  = 1'b1;
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        if (stream_abort) return;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clock);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        forever begin
            @(negedge clock);
            if (byte_ready) begin
                @(posedge clock);
                #1;
                break;
            end
            waited++;
            if (waited > 100) begin
                vectors++;
                miscompares++;
                stream_abort = 1'b1;
                $display("[TB] FAIL byte_accept_timeout: got byte_ready 0 for %0d cycles, required 1", waited);
                @(posedge clock);
                #1;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int max_gap);
        logic [31:0] w;
        build_expected();
        log_addr_q.delete();
        log_data_q.delete();
        foreach (stream_q[i]) begin
            w = stream_q[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            end
        end
    endtask

    task automatic finish_check(input string tag);
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (done || error) break;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
        checkOutput({tag, "_error"}, 32'(error), 32'(exp_error));
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        checkOutput({tag, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        reset      = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        stream_abort = 1'b0;
        #2;
        checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_wren", 32'(imem_wren), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_data", imem_data, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        checkOutput("rel_ready_low", 32'(byte_ready), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("rel_ready_high", 32'(byte_ready), 32'd1);
    endtask

    task automatic load_three_word_stream();
        stream_q.delete();
        stream_q.push_back(32'd3);
        stream_q.push_back(32'h1111_1111);
        stream_q.push_back(32'h2222_2222);
        stream_q.push_back(32'h3333_3333);
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(32'h0000_0000);
`endif
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] w;

        apply_reset();

        // Three-word load, back-to-back bytes.
        load_three_word_stream();
        applyStimulus(0);
        finish_check("n3");
        checkOutput("n3_write_count", 32'(log_addr_q.size()), 32'd3);
        if (log_addr_q.size() == 3) begin
            checkOutput("n3_addr2", log_addr_q[2], 32'd2);
            checkOutput("n3_data1", log_data_q[1], 32'h2222_2222);
        end

        // Same stream with random 0-5 cycle gaps between bytes.
        apply_reset();
        load_three_word_stream();
        applyStimulus(5);
        finish_check("n3_gaps");
        checkOutput("n3_gaps_write_count", 32'(log_addr_q.size()), 32'd3);

        // Oversized header count aborts without writing.
        apply_reset();
        stream_q.delete();
        stream_q.push_back(32'h0000_1001);
        applyStimulus(0);
        finish_check("n_too_big");
        checkOutput("n_too_big_error", 32'(error), 32'd1);
        checkOutput("n_too_big_writes", 32'(log_addr_q.size()), 32'd0);

        // Empty image.
        apply_reset();
        stream_q.delete();
        stream_q.push_back(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(32'd0);
`endif
        applyStimulus(0);
        finish_check("n0");

        // Reset in the middle of the first payload word, then reload.
        apply_reset();
        log_addr_q.delete();
        log_data_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 1);
        send_byte(8'h11, 0);
        apply_reset();
        load_three_word_stream();
        applyStimulus(2);
        finish_check("restart");
        if (log_addr_q.size() > 0) begin
            checkOutput("restart_addr0", log_addr_q[0], 32'd0);
            checkOutput("restart_data0", log_data_q[0], 32'h1111_1111);
        end else begin
            checkOutput("restart_write_count", 32'(log_addr_q.size()), 32'd3);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailer matches the XOR of the payload.
        apply_reset();
        stream_q.delete();
        stream_q.push_back(32'd2);
        stream_q.push_back(32'hA5A5_A5A5);
        stream_q.push_back(32'h0F0F_0F0F);
        stream_q.push_back(32'hAAAA_AAAA);
        applyStimulus(0);
        finish_check("csum_ok");
        checkOutput("csum_ok_done", 32'(done), 32'd1);

        // Trailer off by one bit.
        apply_reset();
        stream_q[3] = 32'hAAAA_AAAB;
        applyStimulus(0);
        finish_check("csum_bad");
        checkOutput("csum_bad_error", 32'(error), 32'd1);
        checkOutput("csum_bad_hold", 32'(cpu_hold), 32'd1);
`endif

        // Full-depth image: addresses 0..4095 and no wrap back to 0.
        apply_reset();
        stream_q.delete();
        stream_q.push_back(32'd4096);
        x = 32'd0;
        for (int i = 0; i < 4096; i++) begin
            w = {i[15:0], ~i[15:0]};
            stream_q.push_back(w);
            x = x ^ w;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(x);
`endif
        applyStimulus(0);
        finish_check("n4096");
        checkOutput("n4096_write_count", 32'(log_addr_q.size()), 32'd4096);
        if (log_addr_q.size() > 0) begin
            checkOutput("n4096_last_addr", log_addr_q[log_addr_q.size()-1], 32'd4095);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no end of test after 5 ms, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, imem word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width; fixed at 4 bytes.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-005 SHALL have port byte_valid, input, 1, source has a byte.
REQ-006 SHALL have port byte_data, input, 8, stream byte.
REQ-007 SHALL have port byte_ready, output, 1, loader accepts a byte; transfer occurs when valid and ready are both high.
REQ-008 SHALL have port imem_wren, output, 1, write strobe toward imem.
REQ-009 SHALL have port imem_addr, output, ADDR_W, write word address.
REQ-010 SHALL have port imem_data, output, DATA_W, write word.
REQ-011 SHALL have port cpu_hold, output, 1, high keeps the processor in reset.
REQ-012 SHALL have port done, output, 1, load completed successfully.
REQ-013 SHALL have port error, output, 1, load aborted.

Function
REQ-014 SHALL assemble words MSB-first: first accepted byte is bits 31:24.
REQ-015 SHALL use FSM states HEADER, LOAD, CHECK, DONE, ERROR.
REQ-016 In HEADER, SHALL take the first word as count N (bits 12:0).
REQ-017 If N > 2^ADDR_W, SHALL go to ERROR.
REQ-018 If N = 0, SHALL go to CHECK when the checksum is enabled, otherwise to DONE.
REQ-019 In LOAD, SHALL assert imem_wren for exactly one cycle, in the cycle after the 4th byte of each word is accepted.
REQ-020 For that write, imem_addr SHALL equal the word index, starting at 0 and incrementing by 1.
REQ-021 After the N-th write, SHALL go to CHECK when the checksum is enabled, otherwise to DONE.
REQ-022 byte_ready SHALL be high in HEADER, LOAD and CHECK, except in the cycle imem_wren is high; it SHALL be low in DONE and ERROR.
REQ-023 byte_valid high while byte_ready is low SHALL NOT be consumed.
REQ-024 A stall of any length between bytes SHALL NOT lose or duplicate a byte.
REQ-025 cpu_hold SHALL be high in all states except DONE.
REQ-026 done SHALL be high only in DONE.
REQ-027 error SHALL be high only in ERROR.
REQ-028 DONE and ERROR SHALL be terminal until reset.
REQ-029 N = 4096 SHALL write addresses 0..4095; the address counter SHALL NOT wrap to rewrite address 0.

Reset
REQ-030 Reset assertion SHALL immediately force:
- state = HEADER
- byte counter = 0, word counter = 0, checksum = 0
- imem_wren = 0, imem_addr = 0, imem_data = 0
- byte_ready = 0, cpu_hold = 1, done = 0, error = 0
REQ-031 byte_ready SHALL rise on the first clock edge after reset deasserts.
REQ-032 Reset during LOAD SHALL discard any partial word and restart at HEADER; memory already written is not cleared.

Configuration
REQ-033 With macro IMEM_LOADER_CHECKSUM_EN defined:
- the loader SHALL keep a running XOR of all N payload words.
- in CHECK it SHALL accept one trailing word.
- on a match it SHALL go to DONE; on a mismatch it SHALL go to ERROR.
REQ-034 Without the macro:
- CHECK and the XOR register SHALL be absent.
- no trailing word SHALL be consumed.
- error SHALL be raised only by REQ-017.

Structure
REQ-035 A shared package SHALL hold:
- the state enum
- constants for word bytes (4) and count width (13)
REQ-036 One sub-module, word_assembler, SHALL be used:
- it shifts bytes into a 32-bit word.
- it outputs a one-cycle word_valid pulse per 4th byte.

Verification
REQ-037 Send N=3, words 0x11111111, 0x22222222, 0x33333333 -> three single-cycle writes at addr 0,1,2 with those data; done=1, cpu_hold=0.
REQ-038 Insert random byte_valid gaps of 0-5 cycles in the REQ-037 stream -> identical writes, no extra imem_wren.
REQ-039 Header N=0x1001 -> error=1, no imem_wren, byte_ready=0.
REQ-040 Checksum enabled, N=2, words 0xA5A5A5A5 and 0x0F0F0F0F, trailer 0xAAAAAAAA -> done=1; with trailer 0xAAAAAAAB instead -> error=1, cpu_hold=1.
REQ-041 Assert reset after 2 bytes of word 1, then resend the full stream -> writes restart at addr 0 with correct data.
REQ-042 N=4096 -> last write at addr 4095, no write at addr 0 after it, then done=1.
